// File: rtl/nx_interface_monitor_skid_pkg.sv
// ============================================================================
// Package : cr_structs
// Brief   : AXI4-Stream datapath beat/ready types and skid-buffer depth bounds.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package cr_structs;

  localparam int NX_IM_SKID_MAX_DEPTH = 16;
  localparam int NX_IM_SKID_MIN_DEPTH = 2;

  localparam int DP_DATA_W = 32;
  localparam int DP_ID_W   = 4;
  localparam int DP_STRB_W = 4;
  localparam int DP_USER_W = 4;

  typedef struct packed {
    logic [DP_DATA_W-1:0] tdata;
    logic [DP_ID_W-1:0]   tid;
    logic                 tlast;
    logic [DP_STRB_W-1:0] tstrb;
    logic [DP_USER_W-1:0] tuser;
    logic                 tvalid;
  } axi4s_dp_bus_t;

  typedef struct packed {
    logic tready;
  } axi4s_dp_rdy_t;

  // Beat payload as stored in the buffer (everything except tvalid)
  typedef struct packed {
    logic [DP_DATA_W-1:0] tdata;
    logic [DP_ID_W-1:0]   tid;
    logic                 tlast;
    logic [DP_STRB_W-1:0] tstrb;
    logic [DP_USER_W-1:0] tuser;
  } axi4s_dp_pay_t;

endpackage

`default_nettype wire

// File: rtl/nx_im_skid_fifo.sv
// ============================================================================
// Module : nx_im_skid_fifo
// Brief  : Circular buffer (any DEPTH) with unreset storage and reset pointers.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module nx_im_skid_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [W-1:0]               wdata_i,
  output logic [W-1:0]               rdata_o,
  output logic [$clog2(DEPTH+1)-1:0] occ_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OW = $clog2(DEPTH+1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [OW-1:0] occ_q, occ_d;

  // Explicit wrap so non-power-of-two depths never index past DEPTH-1
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    wptr_d = push_i ? ptr_inc(wptr_q) : wptr_q;
    rptr_d = pop_i  ? ptr_inc(rptr_q) : rptr_q;
    occ_d  = occ_q;
    if (push_i && !pop_i) begin
      occ_d = occ_q + OW'(1);
    end else if (!push_i && pop_i) begin
      occ_d = occ_q - OW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      occ_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      occ_q  <= occ_d;
    end
  end

  assign rdata_o = mem_q[rptr_q];
  assign occ_o   = occ_q;

endmodule

`default_nettype wire

// File: rtl/nx_interface_monitor_skid.sv
// ============================================================================
// Module : nx_interface_monitor_skid
// Brief  : AXI4-Stream skid buffer gated by an interface monitor ready;
//          optional pop statistics enabled by macro NX_IM_SKID_STATS_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module nx_interface_monitor_skid
  import cr_structs::*;
#(
  parameter int DEPTH       = 4,
  parameter int IM_HOLD_OUT = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  axi4s_dp_bus_t              ib_bus,
  output axi4s_dp_rdy_t              ib_rdy,
  output axi4s_dp_bus_t              ob_bus,
  input  axi4s_dp_rdy_t              ob_rdy,
  input  logic                       im_rdy,
  output logic                       im_vld,
  output logic [$clog2(DEPTH+1)-1:0] occ,
  output logic [31:0]                beat_cnt,
  output logic [15:0]                frame_cnt
);

  localparam int OW = $clog2(DEPTH+1);

  axi4s_dp_pay_t wr_pay;
  axi4s_dp_pay_t head;
  logic          push;
  logic          pop;
  logic          ob_vld;

  // Ready depends only on local occupancy and im_rdy, never on ob_rdy
  assign ib_rdy.tready = (occ < OW'(DEPTH)) && im_rdy;
  assign push          = ib_bus.tvalid && ib_rdy.tready;
  assign im_vld        = push;
  assign ob_vld        = (occ != '0) && ((IM_HOLD_OUT == 0) || im_rdy);
  assign pop           = ob_vld && ob_rdy.tready;

  always_comb begin
    wr_pay.tdata = ib_bus.tdata;
    wr_pay.tid   = ib_bus.tid;
    wr_pay.tlast = ib_bus.tlast;
    wr_pay.tstrb = ib_bus.tstrb;
    wr_pay.tuser = ib_bus.tuser;
  end

  nx_im_skid_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(axi4s_dp_pay_t))
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (wr_pay),
    .rdata_o (head),
    .occ_o   (occ)
  );

  // Storage is unreset, so fields are masked to zero whenever the buffer is empty
  always_comb begin
    ob_bus = '0;
    if (occ != '0) begin
      ob_bus.tdata = head.tdata;
      ob_bus.tid   = head.tid;
      ob_bus.tlast = head.tlast;
      ob_bus.tstrb = head.tstrb;
      ob_bus.tuser = head.tuser;
    end
    ob_bus.tvalid = ob_vld;
  end

`ifdef NX_IM_SKID_STATS_EN
  logic [31:0] beat_cnt_q;
  logic [15:0] frame_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt_q  <= '0;
      frame_cnt_q <= '0;
    end else if (pop) begin
      beat_cnt_q <= beat_cnt_q + 32'd1;
      if (ob_bus.tlast) begin
        frame_cnt_q <= frame_cnt_q + 16'd1;
      end
    end
  end

  assign beat_cnt  = beat_cnt_q;
  assign frame_cnt = frame_cnt_q;
`else
  assign beat_cnt  = '0;
  assign frame_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: doc/nx_interface_monitor_skid.md
NX_INTERFACE_MONITOR_SKID -- requirements
Module: nx_interface_monitor_skid

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of buffered beats (legal range 2..16, any integer).
REQ-002 SHALL have parameter IM_HOLD_OUT, default 0; when 1, ob_bus.tvalid is forced low while im_rdy is low.
REQ-003 SHALL have port clk  in  1  clock; all logic is on the rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port ib_bus  in  axi4s_dp_bus_t  upstream beat (tdata, tid, tlast, tstrb, tuser, tvalid).
REQ-006 SHALL have port ib_rdy  out  axi4s_dp_rdy_t  upstream tready.
REQ-007 SHALL have port ob_bus  out  axi4s_dp_bus_t  downstream beat.
REQ-008 SHALL have port ob_rdy  in  axi4s_dp_rdy_t  downstream tready.
REQ-009 SHALL have port im_rdy  in  1  interface-monitor ready; low stalls admission.
REQ-010 SHALL have port im_vld  out  1  one pulse per admitted beat.
REQ-011 SHALL have port occ  out  $clog2(DEPTH+1)  current buffer occupancy.
REQ-012 SHALL have ports beat_cnt (out, 32) and frame_cnt (out, 16): popped-beat and popped-tlast counters.

Function
REQ-013 SHALL admit a beat in a cycle where push = ib_bus.tvalid & ib_rdy.tready.
REQ-014 SHALL drive ib_rdy.tready = (occ < DEPTH) & im_rdy; no combinational path from ob_rdy to ib_rdy.
REQ-015 SHALL drive im_vld = push in the same cycle (exactly one im_vld per admitted beat).
REQ-016 SHALL drive ob_bus.tvalid = (occ != 0), gated by im_rdy when IM_HOLD_OUT=1; ob_bus fields show the FIFO head.
REQ-017 SHALL pop in a cycle where ob_bus.tvalid & ob_rdy.tready.
REQ-018 SHALL have latency 1: a beat pushed into an empty buffer at cycle N is presented at N+1.
REQ-019 SHALL keep ob_bus fields stable while tvalid is high and tready is low.
REQ-020 SHALL, on simultaneous push and pop, leave occ unchanged and keep beat order.
REQ-021 SHALL, at full (occ=DEPTH), refuse push even when a pop occurs in the same cycle.
REQ-022 SHALL wrap read/write pointers from DEPTH-1 to 0; DEPTH is not required to be a power of two.
REQ-023 SHALL, while im_rdy is low with IM_HOLD_OUT=0, continue draining buffered beats downstream.
REQ-024 SHALL pass tid/tstrb/tuser/tdata/tlast unmodified and never drop or duplicate a beat.

Reset
REQ-025 SHALL, when rst_n is low, reset occ=0, both pointers=0, ob_bus all fields=0, beat_cnt=0, frame_cnt=0.
REQ-026 SHALL, on reset during traffic, discard buffered beats; ib_rdy.tready reflects im_rdy in the first cycle after release.
REQ-027 SHALL leave FIFO storage unreset; only the occupancy and pointer state is reset.

Configuration
REQ-028 SHALL implement beat_cnt/frame_cnt only when macro NX_IM_SKID_STATS_EN is defined; both counters wrap on overflow.
REQ-029 SHALL tie beat_cnt and frame_cnt to 0 when NX_IM_SKID_STATS_EN is undefined; all other behaviour is identical.

Structure
REQ-030 SHALL take axi4s_dp_bus_t/axi4s_dp_rdy_t from package cr_structs; DEPTH bounds are defined there as NX_IM_SKID_MAX_DEPTH=16.
REQ-031 SHALL place storage and pointers in sub-module nx_im_skid_fifo (params DEPTH, W); the top holds the handshake, gating and stats.

Verification
REQ-032 SHALL verify single beat: DEPTH=4, push tdata=0xA5 at cycle 0 -> ob_bus.tvalid=1 at cycle 1, im_vld pulses once at cycle 0.
REQ-033 SHALL verify fill: ob_rdy=0, 4 beats pushed -> occ=4, ib_rdy.tready=0; fifth beat held upstream; ob_rdy=1 -> beats drained in order.
REQ-034 SHALL verify full plus pop: occ=4, push and pop in the same cycle -> push refused, occ=3 next cycle.
REQ-035 SHALL verify im_rdy stall: im_rdy=0 for 5 cycles with occ=2, IM_HOLD_OUT=0 -> no im_vld, 2 beats drain; with IM_HOLD_OUT=1 -> ob_bus.tvalid=0 throughout.
REQ-036 SHALL verify wrap: DEPTH=3, 10 random-backpressure beats with tlast on beats 4 and 10 -> order preserved, beat_cnt=10, frame_cnt=2 (macro defined), 0/0 otherwise.
REQ-037 SHALL verify reset mid-frame: rst_n low with occ=3 -> occ=0, ob_bus=0, counters=0; next pushed beat emerges first.
